mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Responder end of the fetcher's instruction-memory request interface, and of the LSU's data-memory interface.
- Accepts one-cycle request pulses from both clients and queues them.
- Serialises each access onto the byte-wide RAM port (1-cycle read latency), assembles little-endian words and returns a one-cycle ready pulse.
- Honours rollback by cancelling speculative reads.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width (4 bytes)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_rollback  input  1  pipeline flush
in_fetch_ena  input  1  one-cycle fetch request pulse
in_fetch_addr  input  ADDR_WIDTH  fetch address, valid with in_fetch_ena
out_fetch_ready  output  1  one-cycle pulse, instruction valid
out_fetch_inst  output  DATA_WIDTH  assembled instruction
in_lsu_ena  input  1  one-cycle LSU request pulse
in_lsu_wr  input  1  1=store, 0=load
in_lsu_size  input  2  00=byte, 01=half, 10=word (11 treated as word)
in_lsu_addr  input  ADDR_WIDTH  data address
in_lsu_data  input  DATA_WIDTH  store data, low bytes used
out_lsu_ready  output  1  one-cycle pulse, load data valid / store done
out_lsu_data  output  DATA_WIDTH  zero-extended load data
out_ram_addr  output  ADDR_WIDTH  RAM byte address
out_ram_wr  output  1  RAM write strobe
out_ram_data  output  8  RAM write byte
in_ram_data  input  8  RAM read byte, valid the cycle after its address

Behaviour:
- Reset (rst low, async): state IDLE, both pending flags cleared, byte counter 0. All outputs 0.
- Request capture:
  - A pulse on in_fetch_ena or in_lsu_ena, sampled at a rising edge, sets that client's pending flag and latches its address, size and data.
  - Both may arrive in the same cycle. A new pulse from a client already pending is ignored.
- States: IDLE, READ, WRITE.
- Arbitration in IDLE: pending LSU beats pending fetch.
  - Fetch -> READ, length 4.
  - LSU load -> READ, length 1/2/4 by size.
  - LSU store -> WRITE, same length rule.
  - The pending flag clears when its access starts.
- READ, length n; request pulse in cycle 0, serviced immediately if idle:
  - out_ram_addr = base+i during cycles 1..n (i = 0..n-1); out_ram_wr = 0.
  - Byte i is sampled from in_ram_data at the end of cycle i+2 and placed at bits [8i+7:8i]; unread upper bytes are 0.
  - Ready pulse plus data in cycle n+2; state returns to IDLE in that cycle.
  - Word fetch: request in cycle 0, out_fetch_ready high only in cycle 6.
- WRITE, length n:
  - Cycles 1..n: out_ram_wr = 1, out_ram_addr = base+i, out_ram_data = byte i of the store data.
  - out_lsu_ready pulses in cycle n+1.
- Address arithmetic: base+i is an ADDR_WIDTH add with natural wrap; no alignment check.
- Idle outputs: out_ram_addr = 0, out_ram_wr = 0, out_ram_data = 0. Ready outputs are 0 except during their single pulse cycle. Data outputs hold their last value.
- Rollback (sampled at edge):
  - Clears the pending fetch and any pending LSU load.
  - Aborts an active READ: state goes to IDLE next cycle and no ready pulse is issued.
  - Request pulses coinciding with rollback are dropped.
  - Pending or active stores are NOT affected: stores are committed and always complete.
- Back-to-back: a new access may start the cycle after a ready pulse. A request arriving during a ready cycle is latched and serviced next.

Test Plan:
- Fetch alone: RAM bytes at 0x100..0x103 = 13,05,50,00; pulse fetch 0x100 in cycle 0 -> addresses 0x100..0x103 in cycles 1..4, out_fetch_ready only in cycle 6 with out_fetch_inst = 0x00500513.
- Simultaneous requests: fetch 0x0 and LSU load word 0x2000 pulsed together -> LSU access first (ready cycle 6), fetch addresses start cycle 7, fetch ready cycle 12; no extra pulses.
- Half store: store size 01, addr 0x3FFF, data 0xAABBCCDD -> writes DD@0x3FFF and CC@0x4000 in cycles 1-2, out_lsu_ready in cycle 3; byte load of 0x4000 then returns 0x000000CC.
- Rollback in cycle 3 of a fetch -> no out_fetch_ready, RAM idle from cycle 4; fetch 0x8 pulsed cycle 5 returns correctly in cycle 11.
- Rollback during store to 0x10 plus pending fetch -> all 4 store bytes written, out_lsu_ready pulses, pending fetch discarded.
- Async reset asserted mid-READ between edges -> all outputs 0 immediately; after release, a fresh fetch completes with correct latency.

Source files
------------

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//
// Shared byte-wide RAM port for two clients: the instruction fetcher (word
// reads only) and the LSU (byte/half/word loads and stores). Each client
// raises a one-cycle request pulse. The controller queues one request per
// client, serialises the access onto the RAM one byte per cycle, assembles
// read bytes little-endian, and answers with a one-cycle ready pulse.
//
// The RAM returns read data one cycle after the address is presented. A word
// read issued from idle therefore completes with its ready pulse six cycles
// after the request pulse.
//
// A pipeline rollback cancels everything speculative: pending fetches and
// loads, in-flight reads, and any request pulses in the same cycle. Stores are
// already committed, so they always run to completion.
//
// The byte assembly assumes DATA_WIDTH holds exactly four bytes.
//
// Ports
//   clk              clock, all state changes on the rising edge
//   rst              asynchronous active-low reset
//   in_rollback      pipeline flush, sampled at the rising edge
//   in_fetch_ena     fetch request pulse
//   in_fetch_addr    fetch byte address
//   out_fetch_ready  one-cycle pulse, out_fetch_inst valid
//   out_fetch_inst   assembled instruction word (holds between pulses)
//   in_lsu_ena       LSU request pulse
//   in_lsu_wr        1 = store, 0 = load
//   in_lsu_size      00 byte, 01 half, 10/11 word
//   in_lsu_addr      LSU byte address
//   in_lsu_data      store data, low bytes used
//   out_lsu_ready    one-cycle pulse, load data valid or store done
//   out_lsu_data     zero-extended load data (holds between pulses)
//   out_ram_addr     RAM byte address (0 when idle)
//   out_ram_wr       RAM write strobe
//   out_ram_data     RAM write byte
//   in_ram_data      RAM read byte, valid the cycle after its address
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_rollback,
  input  logic                  in_fetch_ena,
  input  logic [ADDR_WIDTH-1:0] in_fetch_addr,
  output logic                  out_fetch_ready,
  output logic [DATA_WIDTH-1:0] out_fetch_inst,
  input  logic                  in_lsu_ena,
  input  logic                  in_lsu_wr,
  input  logic [1:0]            in_lsu_size,
  input  logic [ADDR_WIDTH-1:0] in_lsu_addr,
  input  logic [DATA_WIDTH-1:0] in_lsu_data,
  output logic                  out_lsu_ready,
  output logic [DATA_WIDTH-1:0] out_lsu_data,
  output logic [ADDR_WIDTH-1:0] out_ram_addr,
  output logic                  out_ram_wr,
  output logic [7:0]            out_ram_data,
  input  logic [7:0]            in_ram_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Pending (queued) requests, one slot per client.
  logic                  pend_fetch_q;
  logic [ADDR_WIDTH-1:0] fetch_addr_q;
  logic                  pend_lsu_q;
  logic                  lsu_wr_q;
  logic [1:0]            lsu_size_q;
  logic [ADDR_WIDTH-1:0] lsu_addr_q;
  logic [DATA_WIDTH-1:0] lsu_data_q;

  // Active access.
  logic [ADDR_WIDTH-1:0] base_q;
  logic [2:0]            len_q;      // bytes in this access: 1, 2 or 4
  logic [2:0]            cnt_q;      // cycles spent in the current state
  logic                  is_fetch_q; // read result goes to the fetch port
  logic [DATA_WIDTH-1:0] wdata_q;    // store bytes, shifted down as written
  logic [DATA_WIDTH-1:0] rbuf_q;     // read bytes collected so far

  // Request arbitration signals.
  logic                  fetch_new, lsu_new;
  logic                  fetch_cand, lsu_cand;
  logic [ADDR_WIDTH-1:0] fetch_cand_addr;
  logic                  cand_wr;
  logic [1:0]            cand_size;
  logic [ADDR_WIDTH-1:0] cand_addr;
  logic [DATA_WIDTH-1:0] cand_data;
  logic                  start_fetch, start_lsu;

  // Read assembly.
  logic [1:0]            rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration. A client's candidate request is its queued one if present,
  // otherwise a pulse arriving this cycle, so an idle controller starts a new
  // request on the very edge that samples it. A queued request shadows any
  // new pulse from the same client. Rollback removes every candidate except
  // a queued store.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a value before any branch, so
    // no path can leave one unassigned and infer a latch.
    fetch_new       = in_fetch_ena && !in_rollback && !pend_fetch_q;
    lsu_new         = in_lsu_ena && !in_rollback && !pend_lsu_q;
    fetch_cand      = 1'b0;
    fetch_cand_addr = in_fetch_addr;
    lsu_cand        = 1'b0;
    cand_wr         = in_lsu_wr;
    cand_size       = in_lsu_size;
    cand_addr       = in_lsu_addr;
    cand_data       = in_lsu_data;

    if (pend_lsu_q) begin
      lsu_cand  = !in_rollback || lsu_wr_q;
      cand_wr   = lsu_wr_q;
      cand_size = lsu_size_q;
      cand_addr = lsu_addr_q;
      cand_data = lsu_data_q;
    end else begin
      lsu_cand = lsu_new;
    end

    if (pend_fetch_q) begin
      fetch_cand      = !in_rollback;
      fetch_cand_addr = fetch_addr_q;
    end else begin
      fetch_cand = fetch_new;
    end

    start_lsu   = (state_q == IDLE) && lsu_cand;
    start_fetch = (state_q == IDLE) && !lsu_cand && fetch_cand;
  end

  // ---------------------------------------------------------------------------
  // Read assembly: the byte on in_ram_data now belongs to the address shown
  // one cycle ago, i.e. byte cnt_q-1 of the access.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_idx  = 2'(cnt_q - 3'd1);
    rd_word = rbuf_q;
    rd_word[{rd_idx, 3'b000} +: 8] = in_ram_data;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and RAM port outputs.
  //   READ : cnt 0..len-1 drive addresses; cnt 1..len capture bytes; the
  //          final capture (cnt == len) registers the ready pulse and leaves.
  //   WRITE: cnt 0..len-1 drive one byte each; the last registers ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    out_ram_addr = '0;
    out_ram_wr   = 1'b0;
    out_ram_data = '0;

    case (state_q)
      IDLE: begin
        if (start_lsu) begin
          state_d = cand_wr ? WRITE : READ;
        end else if (start_fetch) begin
          state_d = READ;
        end
      end

      READ: begin
        if (cnt_q < len_q) begin
          out_ram_addr = base_q + ADDR_WIDTH'(cnt_q);
        end
        if (in_rollback || cnt_q == len_q) begin
          state_d = IDLE;
        end
      end

      WRITE: begin
        out_ram_wr   = 1'b1;
        out_ram_addr = base_q + ADDR_WIDTH'(cnt_q);
        out_ram_data = wdata_q[7:0];
        if (cnt_q == len_q - 3'd1) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: registers use non-blocking assignment so every flop samples
      // the pre-edge values of the others, regardless of block order.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request queue, access datapath and ready/data outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_fetch_q    <= 1'b0;
      fetch_addr_q    <= '0;
      pend_lsu_q      <= 1'b0;
      lsu_wr_q        <= 1'b0;
      lsu_size_q      <= '0;
      lsu_addr_q      <= '0;
      lsu_data_q      <= '0;
      base_q          <= '0;
      len_q           <= '0;
      cnt_q           <= '0;
      is_fetch_q      <= 1'b0;
      wdata_q         <= '0;
      rbuf_q          <= '0;
      out_fetch_ready <= 1'b0;
      out_fetch_inst  <= '0;
      out_lsu_ready   <= 1'b0;
      out_lsu_data    <= '0;
    end else begin
      out_fetch_ready <= 1'b0;
      out_lsu_ready   <= 1'b0;

      // Fetch slot: emptied when its access starts or on rollback.
      if (start_fetch || in_rollback) begin
        pend_fetch_q <= 1'b0;
      end else if (fetch_new) begin
        pend_fetch_q <= 1'b1;
        fetch_addr_q <= in_fetch_addr;
      end

      // LSU slot: rollback only discards a queued load, never a store.
      if (start_lsu || (in_rollback && !lsu_wr_q)) begin
        pend_lsu_q <= 1'b0;
      end else if (lsu_new) begin
        pend_lsu_q <= 1'b1;
        lsu_wr_q   <= in_lsu_wr;
        lsu_size_q <= in_lsu_size;
        lsu_addr_q <= in_lsu_addr;
        lsu_data_q <= in_lsu_data;
      end

      case (state_q)
        IDLE: begin
          if (start_lsu || start_fetch) begin
            cnt_q      <= '0;
            rbuf_q     <= '0;
            is_fetch_q <= start_fetch;
            base_q     <= start_lsu ? cand_addr : fetch_cand_addr;
            len_q      <= start_lsu ? size_to_len(cand_size) : 3'd4;
            wdata_q    <= cand_data;
          end
        end

        READ: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q != 3'd0) begin
            rbuf_q <= rd_word;
          end
          // A rollback on the final capture edge still suppresses the pulse.
          if (cnt_q == len_q && !in_rollback) begin
            if (is_fetch_q) begin
              out_fetch_ready <= 1'b1;
              out_fetch_inst  <= rd_word;
            end else begin
              out_lsu_ready <= 1'b1;
              out_lsu_data  <= rd_word;
            end
          end
        end

        WRITE: begin
          cnt_q   <= cnt_q + 3'd1;
          wdata_q <= wdata_q >> 8;
          if (cnt_q == len_q - 3'd1) begin
            out_lsu_ready <= 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
//
// Self-checking bench for mem_ctrl. A byte RAM model answers the DUT's RAM
// port with one cycle of read latency. A separate reference memory is updated
// in program order when stimulus is issued; expected ready pulses (data and
// cycle) and expected RAM writes are pushed into queues, and negedge monitors
// pop and compare whenever the DUT presents a ready pulse or a write strobe.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_rollback = 1'b0;
  logic        in_fetch_ena = 1'b0;
  logic [31:0] in_fetch_addr = '0;
  logic        out_fetch_ready;
  logic [31:0] out_fetch_inst;
  logic        in_lsu_ena = 1'b0;
  logic        in_lsu_wr = 1'b0;
  logic [1:0]  in_lsu_size = '0;
  logic [31:0] in_lsu_addr = '0;
  logic [31:0] in_lsu_data = '0;
  logic        out_lsu_ready;
  logic [31:0] out_lsu_data;
  logic [31:0] out_ram_addr;
  logic        out_ram_wr;
  logic [7:0]  out_ram_data;
  logic [7:0]  in_ram_data = '0;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_rollback     (in_rollback),
    .in_fetch_ena    (in_fetch_ena),
    .in_fetch_addr   (in_fetch_addr),
    .out_fetch_ready (out_fetch_ready),
    .out_fetch_inst  (out_fetch_inst),
    .in_lsu_ena      (in_lsu_ena),
    .in_lsu_wr       (in_lsu_wr),
    .in_lsu_size     (in_lsu_size),
    .in_lsu_addr     (in_lsu_addr),
    .in_lsu_data     (in_lsu_data),
    .out_lsu_ready   (out_lsu_ready),
    .out_lsu_data    (out_lsu_data),
    .out_ram_addr    (out_ram_addr),
    .out_ram_wr      (out_ram_wr),
    .out_ram_data    (out_ram_data),
    .in_ram_data     (in_ram_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Memories: the RAM the DUT talks to, and the reference image.
  // ---------------------------------------------------------------------------
  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ (a[15:8] << 1) ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  // Little-endian, zero-extended n-byte read of the reference image.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = ref_rd(a + 32'(i));
    return w;
  endfunction

  always @(posedge clk) in_ram_data <= ram_rd(out_ram_addr);
  always @(posedge clk) if (out_ram_wr) ram[out_ram_addr] = out_ram_data;

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]     = b;
    ref_mem[a] = b;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
    bit          chk_data;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int unsigned cyc;
  } wr_t;

  rsp_t fq[$];
  rsp_t lq[$];
  wr_t  wq[$];
  rsp_t fe, le;
  wr_t  we;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  always @(negedge clk) begin
    if (out_fetch_ready) begin
      if (fq.size() == 0) flag("fetch_ready_unexpected");
      else begin
        fe = fq.pop_front();
        check("fetch_cycle", 64'(cyc), 64'(fe.cyc));
        check("fetch_inst", 64'(out_fetch_inst), 64'(fe.data));
      end
    end
    if (out_lsu_ready) begin
      if (lq.size() == 0) flag("lsu_ready_unexpected");
      else begin
        le = lq.pop_front();
        check("lsu_cycle", 64'(cyc), 64'(le.cyc));
        if (le.chk_data) check("lsu_data", 64'(out_lsu_data), 64'(le.data));
      end
    end
    if (out_ram_wr) begin
      if (wq.size() == 0) flag("ram_write_unexpected");
      else begin
        we = wq.pop_front();
        check("wr_cycle", 64'(cyc), 64'(we.cyc));
        check("wr_addr", 64'(out_ram_addr), 64'(we.addr));
        check("wr_byte", 64'(out_ram_data), 64'(we.data));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Called just after a rising edge; the pulses stay high
  // for exactly the current cycle. With model set, the expected outcome is
  // computed assuming the controller is idle with nothing queued: the LSU
  // access (if any) goes first, then the fetch.
  // ---------------------------------------------------------------------------
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input bit f, input logic [31:0] fa,
                     input bit l, input bit wr, input logic [1:0] sz,
                     input logic [31:0] la, input logic [31:0] ld,
                     input bit rb, input bit model);
    int unsigned s;
    int          n;
    if (model) begin
      s = cyc + 1;
      n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      if (l && wr) begin
        for (int i = 0; i < n; i++) begin
          wq.push_back('{la + 32'(i), ld[8*i +: 8], s + 32'(i)});
          ref_mem[la + 32'(i)] = ld[8*i +: 8];
        end
        lq.push_back('{32'h0, s + 32'(n), 1'b0});
        s = s + 32'(n) + 1;
      end else if (l) begin
        lq.push_back('{ref_load(la, n), s + 32'(n) + 1, 1'b1});
        s = s + 32'(n) + 2;
      end
      if (f) fq.push_back('{ref_load(fa, 4), s + 5, 1'b1});
    end
    in_fetch_ena  = f;
    in_fetch_addr = fa;
    in_lsu_ena    = l;
    in_lsu_wr     = wr;
    in_lsu_size   = sz;
    in_lsu_addr   = la;
    in_lsu_data   = ld;
    in_rollback   = rb;
    step(1);
    in_fetch_ena = 1'b0;
    in_lsu_ena   = 1'b0;
    in_rollback  = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((fq.size() + lq.size() + wq.size()) != 0 && b < 60) begin
      step(1);
      b++;
    end
    if ((fq.size() + lq.size() + wq.size()) != 0) begin
      flag("drain_timeout");
      fq.delete();
      lq.delete();
      wq.delete();
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFE + 32'($urandom_range(0, 3));
    return 32'($urandom_range(0, 63));
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ram_addr"}, 64'(out_ram_addr), 64'h0);
    check({tag, "_ram_wr"}, 64'(out_ram_wr), 64'h0);
    check({tag, "_ram_data"}, 64'(out_ram_data), 64'h0);
    check({tag, "_fetch_ready"}, 64'(out_fetch_ready), 64'h0);
    check({tag, "_lsu_ready"}, 64'(out_lsu_ready), 64'h0);
    check({tag, "_fetch_inst"}, 64'(out_fetch_inst), 64'h0);
    check({tag, "_lsu_data"}, 64'(out_lsu_data), 64'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence.
  // ---------------------------------------------------------------------------
  int unsigned c0;

  initial begin
    preload(32'h100, 8'h13);
    preload(32'h101, 8'h05);
    preload(32'h102, 8'h50);
    preload(32'h103, 8'h00);

    // Reset state.
    #1 rst = 1'b0;
    step(2);
    check_idle_outputs("reset");
    rst = 1'b1;
    step(1);

    // Fetch alone: addresses 0x100..0x103 in cycles 1..4, ready in cycle 6.
    c0 = cyc;
    req(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    check("fetch_model_word", 64'(fq[0].data), 64'h0050_0513);
    for (int i = 0; i < 4; i++) begin
      check("fetch_addr", 64'(out_ram_addr), 64'(32'h100 + 32'(i)));
      step(1);
    end
    check("fetch_addr_done", 64'(out_ram_addr), 64'h0);
    drain();

    // Simultaneous fetch and word load: load wins, fetch follows.
    req(1'b1, 32'h0, 1'b1, 1'b0, 2'b10, 32'h2000, 32'h0, 1'b0, 1'b1);
    drain();

    // Half store straddling 0x4000, then byte load of the upper byte.
    req(1'b0, 32'h0, 1'b1, 1'b1, 2'b01, 32'h3FFF, 32'hAABB_CCDD, 1'b0, 1'b1);
    drain();
    req(1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h4000, 32'h0, 1'b0, 1'b1);
    drain();

    // Rollback in cycle 3 of a fetch, then a fresh fetch in cycle 5.
    c0 = cyc;
    req(1'b1, 32'h40, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    step(2);
    check("rb_addr_cycle3", 64'(out_ram_addr), 64'h42);
    in_rollback = 1'b1;
    step(1);
    in_rollback = 1'b0;
    check("rb_idle_cycle4", 64'(out_ram_addr), 64'h0);
    step(1);
    check("rb_refetch_cycle", 64'(cyc), 64'(c0 + 5));
    req(1'b1, 32'h8, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    drain();
    step(4);

    // Rollback during a store with a fetch queued behind it.
    req(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'h10, 32'h1234_5678 ^ $urandom(), 1'b0, 1'b1);
    req(1'b1, 32'h20, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    in_rollback = 1'b1;
    step(1);
    in_rollback = 1'b0;
    drain();
    step(10);

    // Requests coinciding with rollback are dropped.
    req(1'b1, 32'h30, 1'b1, 1'b0, 2'b10, 32'h50, 32'h0, 1'b1, 1'b0);
    check("rb_drop_idle", 64'(out_ram_addr), 64'h0);
    step(10);

    // Async reset between edges during a READ.
    req(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    check("pre_reset_addr", 64'(out_ram_addr), 64'h100);
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    step(2);
    rst = 1'b1;
    step(1);
    req(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    drain();
    step(8);

    // Randomized traffic against the reference memory.
    for (int it = 0; it < 60; it++) begin
      int         k;
      bit         f, l, wr;
      logic [1:0] sz;
      k  = $urandom_range(0, 2);
      f  = (k != 1);
      l  = (k != 0);
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      req(f, rand_addr(), l, wr, sz, rand_addr(), $urandom(), 1'b0, 1'b1);
      drain();
      step($urandom_range(0, 3));
    end

    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
